// File: rtl/tap_pkg.sv
// TAP controller package: 1149.1 state encoding and the next-state function.
package tap_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR  = 4'h0,
    EXIT1_DR  = 4'h1,
    SHIFT_DR  = 4'h2,
    PAUSE_DR  = 4'h3,
    SEL_IR    = 4'h4,
    UPDATE_DR = 4'h5,
    CAP_DR    = 4'h6,
    SEL_DR    = 4'h7,
    EXIT2_IR  = 4'h8,
    EXIT1_IR  = 4'h9,
    SHIFT_IR  = 4'hA,
    PAUSE_IR  = 4'hB,
    RTI       = 4'hC,
    UPDATE_IR = 4'hD,
    CAP_IR    = 4'hE,
    TLR       = 4'hF
  } tap_state_t;

  // TAP state graph: one step on the sampled tms value.
  function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = s;
    case (s)
      TLR:       n = tms ? TLR      : RTI;
      RTI:       n = tms ? SEL_DR   : RTI;
      SEL_DR:    n = tms ? SEL_IR   : CAP_DR;
      CAP_DR:    n = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:  n = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:  n = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:  n = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:  n = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR: n = tms ? SEL_DR   : RTI;
      SEL_IR:    n = tms ? TLR      : CAP_IR;
      CAP_IR:    n = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:  n = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:  n = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:  n = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:  n = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR: n = tms ? SEL_DR   : RTI;
      default:   n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tap_clock_gate.sv
// Gated shift clock: enable registered while tck is low, then ANDed with tck,
// so the output can only change on a tck rising edge and never glitches.
module tap_clock_gate (
  input  logic tck,
  input  logic trst,
  input  logic en,
  output logic gclk
);

  logic en_d, en_q;

  // Enable passes straight through; held in a negedge flop below.
  always_comb begin
    en_d = en;
  end

  // Enable captured on negedge so it is stable for the whole high phase.
  always_ff @(negedge tck) begin
    if (trst) en_q <= 1'b0;
    else      en_q <= en_d;
  end

  assign gclk = tck & en_q;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: state register on posedge tck, decoded strobes
// and shift-clock enables registered on negedge tck so they are stable across
// the posedge at which the data/instruction registers act.
// Optional build macro TAP_STATE_DEBUG_EN: exposes tap_state and adds assertions.
module tap_controller
  import tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output logic       testLogicReset,
  output logic       clockDR,
  output logic       captureDR,
  output logic       shiftDR,
  output logic       updateDR,
  output logic       clockIR,
  output logic       captureIR,
  output logic       shiftIR,
  output logic       updateIR,
  output logic       select,
`ifdef TAP_STATE_DEBUG_EN
  output logic [3:0] tap_state,
`endif
  output logic       tdo_en
);

  tap_state_t state_d, state_q;

  logic tlr_d, cap_dr_d, shift_dr_d, upd_dr_d, cap_ir_d, shift_ir_d, upd_ir_d, sel_d, tdo_en_d;
  logic tlr_q, cap_dr_q, shift_dr_q, upd_dr_q, cap_ir_q, shift_ir_q, upd_ir_q, sel_q, tdo_en_q;
  logic clken_dr, clken_ir;

  // Next TAP state from the current state and tms.
  always_comb begin
    state_d = next_state(state_q, tms);
  end

  // TAP state register; trst forces Test-Logic-Reset.
  always_ff @(posedge tck) begin
    if (trst) state_q <= TLR;
    else      state_q <= state_d;
  end

  // Decode strobes from the state just entered at the last posedge.
  always_comb begin
    tlr_d      = (state_q == TLR);
    cap_dr_d   = (state_q == CAP_DR);
    shift_dr_d = (state_q == SHIFT_DR);
    upd_dr_d   = (state_q == UPDATE_DR);
    cap_ir_d   = (state_q == CAP_IR);
    shift_ir_d = (state_q == SHIFT_IR);
    upd_ir_d   = (state_q == UPDATE_IR);
    tdo_en_d   = shift_dr_d | shift_ir_d;
    case (state_q)
      SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR,
      PAUSE_IR, EXIT2_IR, UPDATE_IR: sel_d = 1'b1;
      default:                       sel_d = 1'b0;
    endcase
  end

  // Strobes registered on negedge so consumers see them stable across posedge.
  always_ff @(negedge tck) begin
    if (trst) begin
      tlr_q      <= 1'b1;
      cap_dr_q   <= 1'b0;
      shift_dr_q <= 1'b0;
      upd_dr_q   <= 1'b0;
      cap_ir_q   <= 1'b0;
      shift_ir_q <= 1'b0;
      upd_ir_q   <= 1'b0;
      sel_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
    end else begin
      tlr_q      <= tlr_d;
      cap_dr_q   <= cap_dr_d;
      shift_dr_q <= shift_dr_d;
      upd_dr_q   <= upd_dr_d;
      cap_ir_q   <= cap_ir_d;
      shift_ir_q <= shift_ir_d;
      upd_ir_q   <= upd_ir_d;
      sel_q      <= sel_d;
      tdo_en_q   <= tdo_en_d;
    end
  end

  assign clken_dr = cap_dr_d | shift_dr_d;
  assign clken_ir = cap_ir_d | shift_ir_d;

  tap_clock_gate u_gate_dr (.tck(tck), .trst(trst), .en(clken_dr), .gclk(clockDR));
  tap_clock_gate u_gate_ir (.tck(tck), .trst(trst), .en(clken_ir), .gclk(clockIR));

  assign testLogicReset = tlr_q;
  assign captureDR      = cap_dr_q;
  assign shiftDR        = shift_dr_q;
  assign updateDR       = upd_dr_q;
  assign captureIR      = cap_ir_q;
  assign shiftIR        = shift_ir_q;
  assign updateIR       = upd_ir_q;
  assign select         = sel_q;
  assign tdo_en         = tdo_en_q;

`ifdef TAP_STATE_DEBUG_EN
  assign tap_state = state_q;

  a_state_known: assert property (@(posedge tck) disable iff (trst) !$isunknown(state_q));
  a_clk_strobe_excl: assert property (@(posedge tck) disable iff (trst)
                                      !(clockDR && shiftDR && captureDR));
`endif

endmodule
